// File: rtl/inter_msg_sender_if.sv
// Bundles the game-master message strobe and the inter-board
// Request/Ack pin signals of the inter-board transmitter.
interface inter_msg_sender_if;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       Ack_in;
  logic       inter_ready;
  logic       Request_out;
  logic [5:0] inter_data_out;
  logic       overflow;
  logic       timeout_err;

  // The transmitter itself: consumes messages and Ack, drives the link pins.
  modport master (
    input  ctrl_en, ctrl_msg_type, ctrl_number, Ack_in,
    output inter_ready, Request_out, inter_data_out, overflow, timeout_err
  );

  // Whatever sits around the transmitter: game master plus peer board.
  modport slave (
    output ctrl_en, ctrl_msg_type, ctrl_number, Ack_in,
    input  inter_ready, Request_out, inter_data_out, overflow, timeout_err
  );
endinterface

// File: rtl/inter_msg_sender.sv
// Transmit side of the inter-board link. Game-control messages are queued
// in a small FIFO and each one is sent as a header beat and a number beat,
// each beat using a full four-phase Request/Ack handshake. A watchdog
// aborts any handshake phase that stalls for TIMEOUT_CYCLES cycles.
module inter_msg_sender #(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  inter_msg_sender_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [19:0]   TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    REL0,
    REQ1,
    REL1
  } state_t;

  state_t        state;
  logic [19:0]   timer;
  logic          ack_meta;
  logic          ack_s;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [4:0]    msg_number;
  logic          request_q;
  logic [5:0]    data_q;
  logic          ready_q;
  logic          overflow_q;
  logic          timeout_q;

  // Fullness is judged on the registered count only, so a strobe that
  // lands while full is dropped even if the FSM pops in the same cycle.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = bus.ctrl_en && !full;
  assign pop   = (state == IDLE) && !empty && !ack_s;

  assign bus.Request_out    = request_q;
  assign bus.inter_data_out = data_q;
  assign bus.inter_ready    = ready_q;
  assign bus.overflow       = overflow_q;
  assign bus.timeout_err    = timeout_q;

  // Two-flop synchroniser: Ack comes from the other board's clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= bus.Ack_in;
      ack_s    <= ack_meta;
    end
  end

  // Next occupancy, used both for the count itself and for inter_ready.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Message storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.ctrl_msg_type, bus.ctrl_number};
    end
  end

  // FIFO pointers, occupancy and the back-pressure / overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count      <= count_next;
      ready_q    <= (count_next != FULL_COUNT);
      overflow_q <= bus.ctrl_en && full;
    end
  end

  // Handshake FSM: header beat then number beat, each a four-phase cycle,
  // with the phase timer cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      msg_number <= '0;
      request_q  <= 1'b0;
      data_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state == IDLE) begin
        timer <= '0;
        if (pop) begin
          msg_number <= mem[rd_ptr][4:0];
          data_q     <= {1'b1, 2'b00, mem[rd_ptr][7:5]};
          request_q  <= 1'b1;
          state      <= REQ0;
        end
      end else if (timer == TMO_LAST) begin
        request_q <= 1'b0;
        data_q    <= '0;
        timeout_q <= 1'b1;
        timer     <= '0;
        state     <= IDLE;
      end else begin
        timer <= timer + 20'd1;
        case (state)
          REQ0: begin
            if (ack_s) begin
              request_q <= 1'b0;
              timer     <= '0;
              state     <= REL0;
            end
          end
          REL0: begin
            if (!ack_s) begin
              data_q    <= {1'b0, msg_number};
              request_q <= 1'b1;
              timer     <= '0;
              state     <= REQ1;
            end
          end
          REQ1: begin
            if (ack_s) begin
              request_q <= 1'b0;
              timer     <= '0;
              state     <= REL1;
            end
          end
          REL1: begin
            if (!ack_s) begin
              data_q <= '0;
              timer  <= '0;
              state  <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
